// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-buffer drain states.
// The receive-side FIFO is expected to reuse this package.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXF_IDLE,
        TXF_ACK,
        TXF_DRAIN
    } tx_fifo_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered pointers and an occupancy counter.
// The counter has one more bit than the pointers, so full and empty can never be confused.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left without reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter: queues bytes from the I/O write path
// and hands them to the transmitter one at a time using its send pulse / busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   clr_overflow,
    input  logic                   tx_busy,
    output logic                   tx_send,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   timeout
);

    localparam int              TW         = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    tx_fifo_state_e         state;
    tx_fifo_state_e         state_next;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_next;
    logic                   send_next;
    logic                   pop;
    logic                   timeout_hit;
    logic [UART_DATA_W-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .pop       (pop),
        .push_data (wr_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // ACK waits a bounded time for the transmitter to acknowledge; DRAIN waits for it to finish.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        send_next   = 1'b0;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            TXF_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop        = 1'b1;
                    send_next  = 1'b1;
                    timer_next = '0;
                    state_next = TXF_ACK;
                end
            end
            TXF_ACK: begin
                if (tx_busy) begin
                    state_next = TXF_DRAIN;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = TXF_IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            TXF_DRAIN: begin
                if (!tx_busy) state_next = TXF_IDLE;
            end
            default: state_next = TXF_IDLE;
        endcase
    end

    // Setting a sticky flag takes precedence over clearing it in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TXF_IDLE;
            timer    <= '0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            tx_send <= send_next;
            if (pop) tx_data <= head;
            if (wr_en && full)     overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (timeout_hit)       timeout <= 1'b1;
            else if (clr_overflow) timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, and a randomized soak phase.
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_en = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic                   clr_overflow = 1'b0;
    logic                   tx_busy = 1'b0;
    logic                   tx_send;
    logic [7:0]             tx_data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   timeout;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue plus the handshake rules, updated on each rising edge.
    byte unsigned m_q[$];
    logic         m_send     = 1'b0;
    logic [7:0]   m_data     = 8'h00;
    logic         m_ovf      = 1'b0;
    logic         m_tmo      = 1'b0;
    logic         m_engaged  = 1'b0;
    logic         m_acked    = 1'b0;
    int           m_since    = 0;
    logic         m_was_full;
    logic         m_tmo_set;
    logic         m_start;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_send    = 1'b0;
            m_data    = 8'h00;
            m_ovf     = 1'b0;
            m_tmo     = 1'b0;
            m_engaged = 1'b0;
            m_acked   = 1'b0;
            m_since   = 0;
        end else begin
            m_was_full = (m_q.size() == DEPTH);
            m_tmo_set  = 1'b0;
            m_start    = 1'b0;
            if (!m_engaged) begin
                m_start = (m_q.size() != 0) && !tx_busy;
            end else if (!m_acked) begin
                if (tx_busy)                          m_acked = 1'b1;
                else if (m_since == ACK_TIMEOUT - 1) begin
                    m_tmo_set = 1'b1;
                    m_engaged = 1'b0;
                end else                              m_since++;
            end else if (!tx_busy) begin
                m_engaged = 1'b0;
            end
            m_send = m_start;
            if (m_start) begin
                m_data    = m_q.pop_front();
                m_engaged = 1'b1;
                m_acked   = 1'b0;
                m_since   = 0;
            end
            if (wr_en && !m_was_full) m_q.push_back(wr_data);
            m_ovf = (wr_en && m_was_full) ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
            m_tmo = m_tmo_set ? 1'b1 : (clr_overflow ? 1'b0 : m_tmo);
        end
    end

    task automatic check_output();
        check("tx_send",  tx_send,  m_send);
        check("tx_data",  tx_data,  m_data);
        check("count",    count,    m_q.size());
        check("full",     full,     m_q.size() == DEPTH);
        check("empty",    empty,    m_q.size() == 0);
        check("overflow", overflow, m_ovf);
        check("timeout",  timeout,  m_tmo);
    endtask

    always @(negedge clk) if (cmp_en) check_output();

    byte unsigned log_data[$];
    int           log_cyc[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && tx_send === 1'b1) begin
            log_data.push_back(tx_data);
            log_cyc.push_back(cyc);
        end
    end

    // Transmitter stand-in: busy rises the cycle after a send pulse and lasts busy_len cycles.
    typedef enum int {BUSY_NORMAL, BUSY_STUCK, BUSY_DEAD} busy_mode_e;
    busy_mode_e busy_mode = BUSY_NORMAL;
    int         busy_len  = 10;
    int         busy_left = 0;

    task automatic apply_stimulus(input logic wr, input logic [7:0] data, input logic clr);
        case (busy_mode)
            BUSY_STUCK: begin tx_busy = 1'b1; busy_left = 0; end
            BUSY_DEAD:  begin tx_busy = 1'b0; busy_left = 0; end
            default: begin
                if (busy_left > 0) begin
                    tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (tx_send === 1'b1) busy_left = busy_len;
            end
        endcase
        wr_en        = wr;
        wr_data      = data;
        clr_overflow = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drained(input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (n < budget) begin
            done = (m_q.size() == 0) && !m_engaged && (busy_left == 0) && !tx_busy;
            if (done) break;
            apply_stimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         c0;
        int         mk;
        int         guard;
        byte unsigned wl[$];
        logic [7:0] d;

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;
        check("rst_count",    count,    0);
        check("rst_empty",    empty,    1);
        check("rst_full",     full,     0);
        check("rst_tx_send",  tx_send,  0);
        check("rst_tx_data",  tx_data,  8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_timeout",  timeout,  0);

        $display("[TB] single byte");
        busy_mode = BUSY_NORMAL;
        busy_len  = 10;
        c0 = cyc;
        mk = log_data.size();
        apply_stimulus(1'b1, 8'hA5, 1'b0);
        check("single_empty_c1", empty, 0);
        idle(1);
        check("single_send_c2", tx_send, 1);
        check("single_data_c2", tx_data, 8'hA5);
        check("single_empty_c2", empty, 1);
        wait_drained(100);
        check("single_sends", log_data.size() - mk, 1);
        check("single_send_cycle", log_cyc[mk], c0 + 2);

        $display("[TB] burst and order");
        busy_mode = BUSY_STUCK;
        mk = log_data.size();
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'(i + 1), 1'b0);
        check("burst_full", full, 1);
        check("burst_count", count, 16);
        busy_mode = BUSY_NORMAL;
        busy_len  = 4;
        wait_drained(400);
        check("burst_sends", log_data.size() - mk, 16);
        for (int i = 0; i < 16; i++) check("burst_order", log_data[mk + i], i + 1);
        check("burst_overflow", overflow, 0);

        $display("[TB] overflow");
        busy_mode = BUSY_STUCK;
        mk = log_data.size();
        for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 8'(8'h80 + i), 1'b0);
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        apply_stimulus(1'b1, 8'hEE, 1'b1);
        check("ovf_set_wins", overflow, 1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check("ovf_cleared", overflow, 0);
        busy_mode = BUSY_NORMAL;
        wait_drained(400);
        check("ovf_sends", log_data.size() - mk, 16);
        for (int i = 0; i < 16; i++) check("ovf_order", log_data[mk + i], 8'h80 + i);

        $display("[TB] simultaneous push and pop");
        busy_mode = BUSY_STUCK;
        mk = log_data.size();
        apply_stimulus(1'b1, 8'h55, 1'b0);
        check("pp_count_before", count, 1);
        busy_mode = BUSY_NORMAL;
        busy_len  = 5;
        apply_stimulus(1'b1, 8'h66, 1'b0);
        check("pp_count_after", count, 1);
        check("pp_send", tx_send, 1);
        check("pp_data", tx_data, 8'h55);
        wait_drained(100);
        check("pp_sends", log_data.size() - mk, 2);
        check("pp_second", log_data[mk + 1], 8'h66);

        $display("[TB] timeout");
        busy_mode = BUSY_DEAD;
        c0 = cyc;
        mk = log_data.size();
        apply_stimulus(1'b1, 8'h3C, 1'b0);
        idle(4);
        check("tmo_not_yet", timeout, 0);
        idle(1);
        check("tmo_set", timeout, 1);
        check("tmo_sends", log_data.size() - mk, 1);
        check("tmo_send_cycle", log_cyc[mk], c0 + 2);
        busy_mode = BUSY_NORMAL;
        busy_len  = 3;
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        wait_drained(100);
        check("tmo_next_sends", log_data.size() - mk, 2);
        check("tmo_next_data", log_data[mk + 1], 8'hC3);
        check("tmo_sticky", timeout, 1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check("tmo_cleared", timeout, 0);

        $display("[TB] pointer wrap");
        mk    = log_data.size();
        guard = 0;
        while (wl.size() < 40 && guard < 3000) begin
            busy_len = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0 && m_q.size() < DEPTH) begin
                d = 8'($urandom);
                wl.push_back(d);
                apply_stimulus(1'b1, d, 1'b0);
            end else begin
                apply_stimulus(1'b0, 8'h00, 1'b0);
            end
            guard++;
        end
        wait_drained(400);
        check("wrap_sends", log_data.size() - mk, 40);
        for (int i = 0; i < 40; i++) check("wrap_order", log_data[mk + i], wl[i]);

        $display("[TB] random soak");
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                case ($urandom_range(0, 5))
                    0:       busy_mode = BUSY_STUCK;
                    1:       busy_mode = BUSY_DEAD;
                    default: busy_mode = BUSY_NORMAL;
                endcase
            end
            busy_len = $urandom_range(1, 8);
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) == 0);
        end
        busy_mode = BUSY_NORMAL;
        wait_drained(600);

        $display("[TB] reset mid-drain");
        busy_mode = BUSY_NORMAL;
        busy_len  = 10;
        apply_stimulus(1'b1, 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        idle(2);
        check("rd_count_before", count, 3);
        check("rd_data_before", tx_data, 8'h11);
        #2 rst = 1'b0;
        #1;
        check("rd_count", count, 0);
        check("rd_empty", empty, 1);
        check("rd_tx_send", tx_send, 0);
        check("rd_tx_data", tx_data, 8'h00);
        busy_left = 0;
        tx_busy   = 1'b0;
        wr_en     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mk  = log_data.size();
        idle(30);
        check("rd_no_send", log_data.size() - mk, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the UART transmitter inside the UART core. It accepts bytes from the memory-mapped I/O write path and stores them in a FIFO. It drains the FIFO into the transmitter one byte at a time using the transmitter's single-cycle send pulse and busy handshake. This lets software queue several bytes back-to-back instead of polling busy before every store.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after a send pulse before abandoning the byte

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  push wr_data this cycle (one-cycle strobe from the I/O register write decode)
wr_data  in  8  byte to queue
clr_overflow  in  1  clears the sticky overflow flag
tx_busy  in  1  busy from the transmitter
tx_send  out  1  one-cycle send pulse to the transmitter
tx_data  out  8  byte presented to the transmitter; stable from the send pulse until the next send
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  number of queued bytes
overflow  out  1  sticky: a write was dropped because the FIFO was full
timeout  out  1  sticky: tx_busy never rose within ACK_TIMEOUT cycles; cleared with clr_overflow

Behaviour:
- Reset (rst=0, asynchronous):
  - pointers and count cleared; state IDLE.
  - tx_send=0, tx_data=8'h00, overflow=0, timeout=0, empty=1, full=0.
  - FIFO contents undefined.
  - Reset mid-transfer discards all queued bytes. The transmitter is reset by the same rst.
- Write path:
  - wr_en with full=0 stores at the write pointer; count+1 on the next edge.
  - wr_en with full=1 drops the byte and sets overflow. This applies even if a pop occurs in the same cycle, because full is judged from registered state.
  - Pointers wrap modulo DEPTH; count is DEPTH+1-valued, so full and empty are unambiguous.
- Simultaneous push and pop (not full): both occur and count is unchanged.
- Pop never occurs when empty=1, so a push into an empty FIFO cannot be popped in the same cycle.
- Drain FSM, states IDLE, ACK, DRAIN:
  - IDLE: if empty=0 and tx_busy=0, then on the edge: tx_data<=head, tx_send<=1, pop, timer<=0, go to ACK. Otherwise stay.
  - ACK: tx_send<=0 (the pulse lasts exactly one cycle).
    - If tx_busy=1, go to DRAIN.
    - Else if timer==ACK_TIMEOUT-1, set timeout and go to IDLE; the byte is lost.
    - Else timer+1.
  - DRAIN: when tx_busy=0, go to IDLE.
- Latency:
  - wr_en at cycle 0 into an empty FIFO with an idle transmitter gives empty=0 in cycle 1 and tx_send=1 in cycle 2.
  - Minimum gap between send pulses = (transmitter busy duration) + 3 cycles.
- Flag precedence:
  - overflow set and clr_overflow in the same cycle: set wins (overflow=1).
  - The same rule applies to timeout.
- tx_data holds its last value while in IDLE; it is only updated on a pop.
- No combinational path from any input to any output. All outputs are registered or decoded from registered state.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8.
  - typedef enum logic[1:0] tx_fifo_state_e {TXF_IDLE, TXF_ACK, TXF_DRAIN}.
  - Shared with a future rx FIFO.
- Natural sub-module: sync_fifo, a generic DEPTH x width storage with pointers, count, full, empty and push/pop.
- uart_tx_fifo itself holds only the drain FSM, timer and sticky flags.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-DRAIN with 3 bytes queued.
  - Required: count=0, empty=1, tx_send=0, tx_data=0 immediately (asynchronously); after release, no tx_send is issued.
- Single byte:
  - Stimulus: write 8'hA5 at cycle 0; model busy rising 1 cycle after send and lasting 10 cycles.
  - Required: tx_send high only in cycle 2 with tx_data=8'hA5; FSM returns to IDLE after busy falls; empty=1 throughout the transfer.
- Burst and order:
  - Stimulus: write 8'h01..8'h10 on consecutive cycles.
  - Required: full=1 after the 16th write (before any drain-out empties it); sends occur in order 01..10 with exactly one tx_send per byte; overflow=0.
- Overflow:
  - Stimulus: hold tx_busy=1, then write 17 bytes.
  - Required: count=16, overflow=1, the 17th byte is never sent.
  - Then pulse clr_overflow together with another write while still full: overflow stays 1. Pulse clr_overflow alone: overflow=0.
- Simultaneous push and pop:
  - Stimulus: with count=1, write in the same cycle the FSM pops.
  - Required: count stays 1.
  - Pointer wrap: run 40 bytes through DEPTH=16; the data sequence is intact.
- Timeout:
  - Stimulus: tie tx_busy=0 and write 8'h3C.
  - Required: one tx_send, timeout=1 four cycles later, FSM back in IDLE, next queued byte sent normally.
